// File: rtl/sram_bus_pkg.sv
// Shared definitions for the core-bus SRAM responder and its helpers.
// Holds the bus widths, the FSM state type and the wait-parameter legality check.
package sram_bus_pkg;

    localparam int unsigned BUS_AW = 24;
    localparam int unsigned BUS_DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        WR_REC,
        DONE
    } state_t;

    // Wait counts must fit the 4-bit timer and be at least one cycle.
    function automatic bit wait_legal(input int unsigned w);
        return (w >= 1) && (w <= 15);
    endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// 4-bit loadable down-counter with a zero flag, used to time SRAM strobes.
// It stops at zero rather than wrapping.
module sram_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_value,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_responder.sv
// Core-bus responder driving a 16-bit asynchronous SRAM with programmable wait cycles.
// core_hold decodes from registered state only, so req never reaches it combinationally.
module sram_responder
    import sram_bus_pkg::*;
#(
    parameter int unsigned RD_WAIT = 4,
    parameter int unsigned WR_WAIT = 4,
    parameter int unsigned MEM_AW  = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [BUS_AW-1:0] addr,
    input  logic              write_enable,
    input  logic [BUS_DW-1:0] write_data,
    output logic [BUS_DW-1:0] read_data,
    output logic              core_hold,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [BUS_DW-1:0] mem_dq_out,
    input  logic [BUS_DW-1:0] mem_dq_in,
    output logic              mem_dq_oe,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

    if (!wait_legal(RD_WAIT)) begin : g_bad_rd_wait
        $error("RD_WAIT must be in 1..15");
    end
    if (!wait_legal(WR_WAIT)) begin : g_bad_wr_wait
        $error("WR_WAIT must be in 1..15");
    end
    if ((MEM_AW < 1) || (MEM_AW > BUS_AW)) begin : g_bad_mem_aw
        $error("MEM_AW must be in 1..BUS_AW");
    end

    state_t     state;
    logic       accept;
    logic       in_range;
    logic       timer_load;
    logic       timer_en;
    logic       timer_zero;
    logic [3:0] timer_value;

    assign accept      = ((state == IDLE) || (state == DONE)) && req;
    assign in_range    = ((addr >> MEM_AW) == '0);
    assign timer_load  = accept && in_range;
    assign timer_en    = (state == RD) || (state == WR);
    assign timer_value = write_enable ? 4'(WR_WAIT - 1) : 4'(RD_WAIT - 1);
    assign core_hold   = (state == RD) || (state == WR) || (state == WR_REC);

    sram_wait_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .en         (timer_en),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            read_data  <= '0;
            mem_addr   <= '0;
            mem_dq_out <= '0;
            mem_dq_oe  <= 1'b0;
            mem_ce_n   <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    mem_ce_n  <= 1'b1;
                    mem_oe_n  <= 1'b1;
                    mem_we_n  <= 1'b1;
                    mem_dq_oe <= 1'b0;
                    state     <= IDLE;
                    if (req) begin
                        mem_addr <= addr[MEM_AW-1:0];
                        if (!in_range) begin
                            // Out-of-range: no SRAM cycle, reads return zero, writes vanish.
                            state <= DONE;
                            if (!write_enable) begin
                                read_data <= '0;
                            end
                        end else if (write_enable) begin
                            state      <= WR;
                            mem_dq_out <= write_data;
                            mem_ce_n   <= 1'b0;
                            mem_we_n   <= 1'b0;
                            mem_dq_oe  <= 1'b1;
                        end else begin
                            state    <= RD;
                            mem_ce_n <= 1'b0;
                            mem_oe_n <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (timer_zero) begin
                        read_data <= mem_dq_in;
                        mem_ce_n  <= 1'b1;
                        mem_oe_n  <= 1'b1;
                        state     <= DONE;
                    end
                end
                WR: begin
                    if (timer_zero) begin
                        mem_ce_n <= 1'b1;
                        mem_we_n <= 1'b1;
                        state    <= WR_REC;
                    end
                end
                WR_REC: begin
                    // Data and address stay driven one extra cycle after we_n rises.
                    mem_dq_oe <= 1'b0;
                    state     <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: stimulus pushes expected per-access results,
// a negedge monitor measures each access and compares when hold drops.
module tb_sram_responder;

    logic        clk;
    logic        rst;
    logic        req;
    logic [23:0] addr;
    logic        write_enable;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        core_hold;
    logic [22:0] mem_addr;
    logic [15:0] mem_dq_out;
    logic [15:0] mem_dq_in;
    logic        mem_dq_oe;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;

    int checks = 0;
    int errors = 0;
    logic track = 1'b0;

    typedef struct {
        logic        is_write;
        logic        oor;
        logic [23:0] a;
        logic [15:0] rd;
        logic [15:0] mv;
        int          hold;
        int          ce;
        int          oe;
        int          we;
        int          dqoe;
    } exp_t;

    exp_t q[$];

    sram_responder #(.RD_WAIT(4), .WR_WAIT(4), .MEM_AW(23)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .addr         (addr),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_data    (read_data),
        .core_hold    (core_hold),
        .mem_addr     (mem_addr),
        .mem_dq_out   (mem_dq_out),
        .mem_dq_in    (mem_dq_in),
        .mem_dq_oe    (mem_dq_oe),
        .mem_ce_n     (mem_ce_n),
        .mem_oe_n     (mem_oe_n),
        .mem_we_n     (mem_we_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: 64K-word window, preloaded, written while we_n/ce_n are low.
    logic [15:0] sram [0:65535];
    initial begin
        for (int unsigned i = 0; i < 65536; i++) sram[i] = 16'h0000;
        sram[16'h0100] = 16'h1111;
        sram[16'h1234] = 16'hBEEF;
        sram[16'h2000] = 16'hA5A5;
        forever begin
            @(negedge clk);
            if (!mem_we_n && !mem_ce_n && mem_dq_oe) sram[mem_addr[15:0]] = mem_dq_out;
        end
    end
    assign mem_dq_in = (!mem_ce_n && !mem_oe_n) ? sram[mem_addr[15:0]] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic w, input logic [23:0] a, input logic [15:0] rd,
                                input logic [15:0] mv, input int hold, input int ce,
                                input int oe, input int we, input int dqoe);
        exp_t e;
        e.is_write = w;
        e.oor      = a[23];
        e.a        = a;
        e.rd       = rd;
        e.mv       = mv;
        e.hold     = hold;
        e.ce       = ce;
        e.oe       = oe;
        e.we       = we;
        e.dqoe     = dqoe;
        return e;
    endfunction

    // Monitor: an accept is seen as req high while hold is low; completion is hold low again.
    logic        active = 1'b0;
    exp_t        cur;
    int          n_hold, n_ce, n_oe, n_we, n_dqoe;
    logic [15:0] rd_before;
    logic        disturbed;

    always @(negedge clk) begin
        if (rst || !track) begin
            active = 1'b0;
        end else begin
            if (active) begin
                if (core_hold) n_hold++;
                if (!mem_ce_n) n_ce++;
                if (!mem_oe_n) n_oe++;
                if (!mem_we_n) n_we++;
                if (mem_dq_oe) n_dqoe++;
                if (cur.is_write && (read_data !== rd_before)) disturbed = 1'b1;
                if (!core_hold) begin
                    active = 1'b0;
                    chk("hold_cycles", n_hold, cur.hold);
                    chk("ce_cycles", n_ce, cur.ce);
                    chk("oe_cycles", n_oe, cur.oe);
                    chk("we_cycles", n_we, cur.we);
                    chk("dq_oe_cycles", n_dqoe, cur.dqoe);
                    chk("read_data", 32'(read_data), 32'(cur.rd));
                    if (!cur.oor) chk("mem_addr", 32'(mem_addr), 32'(cur.a[22:0]));
                    if (cur.is_write) begin
                        chk("sram_word", 32'(sram[cur.a[15:0]]), 32'(cur.mv));
                        chk("rd_undisturbed", 32'(disturbed), 32'd0);
                    end
                end
            end
            if (req && !core_hold) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_accept actual=accept required=none");
                end else begin
                    cur       = q.pop_front();
                    active    = 1'b1;
                    n_hold    = 0;
                    n_ce      = 0;
                    n_oe      = 0;
                    n_we      = 0;
                    n_dqoe    = 0;
                    rd_before = read_data;
                    disturbed = 1'b0;
                end
            end
        end
    end

    // Drive one request pulse once the responder is free to accept it.
    task automatic issue(input logic w, input logic [23:0] a, input logic [15:0] d);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (core_hold && (n < 100));
        if (core_hold) begin
            errors++;
            $display("FAIL hold_timeout actual=1 required=0");
        end
        req          = 1'b1;
        addr         = a;
        write_enable = w;
        write_data   = d;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        req          = 1'b0;
        addr         = '0;
        write_enable = 1'b0;
        write_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_data", 32'(read_data), 32'h0);
        chk("rst_hold", 32'(core_hold), 32'h0);
        chk("rst_ce_n", 32'(mem_ce_n), 32'h1);
        chk("rst_oe_n", 32'(mem_oe_n), 32'h1);
        chk("rst_we_n", 32'(mem_we_n), 32'h1);
        chk("rst_dq_oe", 32'(mem_dq_oe), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_dq_out", 32'(mem_dq_out), 32'h0);
        rst = 1'b0;

        // Reset in the middle of a read: strobes must drop at once, nothing retried.
        issue(1'b0, 24'h000100, 16'h0000);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ce_n", 32'(mem_ce_n), 32'h1);
        chk("abort_oe_n", 32'(mem_oe_n), 32'h1);
        chk("abort_hold", 32'(core_hold), 32'h0);
        chk("abort_read_data", 32'(read_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_idle", 32'(core_hold), 32'h0);
        track = 1'b1;

        q.push_back(mk(1'b0, 24'h001234, 16'hBEEF, 16'h0000, 4, 4, 4, 0, 0));
        issue(1'b0, 24'h001234, 16'h0000);

        q.push_back(mk(1'b1, 24'h00ABCD, 16'hBEEF, 16'h1234, 5, 4, 0, 4, 5));
        issue(1'b1, 24'h00ABCD, 16'h1234);

        // Store then fetch back-to-back from the DONE cycle.
        q.push_back(mk(1'b1, 24'h000010, 16'hBEEF, 16'h5555, 5, 4, 0, 4, 5));
        issue(1'b1, 24'h000010, 16'h5555);
        q.push_back(mk(1'b0, 24'h000010, 16'h5555, 16'h0000, 4, 4, 4, 0, 0));
        issue(1'b0, 24'h000010, 16'h0000);
        chk("b2b_hold", 32'(core_hold), 32'h1);

        q.push_back(mk(1'b0, 24'h001234, 16'hBEEF, 16'h0000, 4, 4, 4, 0, 0));
        issue(1'b0, 24'h001234, 16'h0000);
        q.push_back(mk(1'b0, 24'h800010, 16'h0000, 16'h0000, 0, 0, 0, 0, 0));
        issue(1'b0, 24'h800010, 16'h0000);

        q.push_back(mk(1'b0, 24'h002000, 16'hA5A5, 16'h0000, 4, 4, 4, 0, 0));
        issue(1'b0, 24'h002000, 16'h0000);
        q.push_back(mk(1'b1, 24'h003000, 16'hA5A5, 16'h0F0F, 5, 4, 0, 4, 5));
        issue(1'b1, 24'h003000, 16'h0F0F);

        q.push_back(mk(1'b1, 24'h800020, 16'hA5A5, 16'h0000, 0, 0, 0, 0, 0));
        issue(1'b1, 24'h800020, 16'h7777);

        for (int i = 0; (i < 200) && ((q.size() != 0) || active); i++) @(posedge clk);
        if ((q.size() != 0) || active) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
Memory-side responder for the Core's single-initiator bus (req/addr/write_enable/write_data/read_data/core_hold).
- Accepts one request per handshake and drives a 16-bit asynchronous external SRAM (cellular RAM, async mode) with programmable wait cycles.
- Freezes the core with core_hold for the duration of each access.
- Sits between Core and the board memory pins; the audio sample buffer and program space both live behind it.

Parameters:
RD_WAIT, 4, cycles ce_n/oe_n held low before read data is captured (legal 1..15)
WR_WAIT, 4, cycles we_n held low per write (legal 1..15)
MEM_AW, 23, external SRAM address width; bus addr[MEM_AW-1:0] is used

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  1  core request strobe, valid for one cycle
addr  in  24  core word address
write_enable  in  1  1 = write, 0 = read; qualified by req
write_data  in  16  write data; qualified by req
read_data  out  16  registered read data, held until the next read completes
core_hold  out  1  freezes the core while an access is in flight
mem_addr  out  MEM_AW  SRAM address (registered)
mem_dq_out  out  16  SRAM data to the pad
mem_dq_in  in  16  SRAM data from the pad
mem_dq_oe  out  1  pad output enable
mem_ce_n  out  1  chip enable, active low
mem_oe_n  out  1  output enable, active low
mem_we_n  out  1  write enable, active low

Behaviour:
- Reset: one clock, clk; reset asynchronous active-high on rst.
  - Asserting rst forces IDLE immediately, including mid-access.
  - Reset values: read_data=0, core_hold=0, mem_ce_n=mem_oe_n=mem_we_n=1, mem_dq_oe=0, mem_addr=0, mem_dq_out=0.
  - An access aborted by reset is not retried.
- States: IDLE, RD, WR, WR_REC, DONE.
- core_hold decodes from registered state only: 1 in RD, WR, WR_REC; 0 in IDLE, DONE.
  - No combinational path from req to core_hold. Core gates req with core_hold, so such a path would form a loop.
- Accept: req sampled high in IDLE or DONE latches addr, write_enable and write_data.
  - Read -> RD; write -> WR. The wait counter loads with RD_WAIT-1 or WR_WAIT-1.
  - req in any other state is ignored; it cannot occur while hold=1.
- RD: mem_ce_n=0, mem_oe_n=0, mem_dq_oe=0; counter decrements each cycle.
  - At count 0, mem_dq_in registers into read_data -> DONE.
- WR: mem_ce_n=0, mem_we_n=0, mem_dq_oe=1, mem_dq_out=latched data.
  - At count 0 -> WR_REC.
- WR_REC: one cycle with mem_we_n=1 and mem_ce_n=1. mem_dq_oe=1 and mem_addr stay stable for data/address hold -> DONE.
- DONE: core_hold=0 for one cycle. The core samples read_data at this edge.
  - With no new req -> IDLE. With a new req -> new access directly (back-to-back).
- Latency:
  - Read accepted at edge E: hold is high for RD_WAIT cycles; read_data is valid and hold=0 from edge E+RD_WAIT.
  - Write: hold is high for WR_WAIT+1 cycles.
- Out-of-range: addr[23:MEM_AW]!=0 skips the SRAM and goes straight to DONE. Hold is never raised.
  - Read returns 16'h0000 into read_data; write is dropped; strobes stay idle.
- read_data changes only on read completion (including out-of-range reads). Writes never disturb it.
- mem_addr updates only on accept and holds until the next accept.
- All SRAM control outputs are registered (glitch-free pins).

Decomposition:
- Package sram_bus_pkg holds:
  - state enum (IDLE, RD, WR, WR_REC, DONE);
  - BUS_AW=24 and BUS_DW=16;
  - parameter legality checks (RD_WAIT, WR_WAIT in 1..15).
- Sub-module sram_wait_timer: 4-bit loadable down-counter with load, load_value, and a zero flag.
  - Reused later by the audio DMA port.

Test Plan:
1. Reset mid-read: read req to 0x000100, assert rst during RD cycle 2 -> ce_n/oe_n=1 and hold=0 immediately; read_data=0; next req served normally.
2. Single read: SRAM model returns 16'hBEEF at 0x001234, req with we=0, RD_WAIT=4 -> hold high exactly 4 cycles; ce_n/oe_n low 4 cycles; read_data=16'hBEEF when hold falls.
3. Single write: req we=1, addr 0x00ABCD, data 16'h1234, WR_WAIT=4 -> we_n low 4 cycles, then 1 recovery cycle with dq_oe=1; hold high 5 cycles; SRAM model holds 16'h1234 at 0x00ABCD.
4. Back-to-back store then fetch: write 16'h5555 to 0x10, req read of 0x10 in the DONE cycle -> no IDLE cycle between accesses; read_data=16'h5555.
5. Out-of-range read: addr 0x800010 with read_data holding 16'hBEEF -> hold never asserted; SRAM strobes idle; read_data=0 on the next edge.
6. Writes leave read_data alone: read 16'hA5A5, then write 16'h0F0F elsewhere -> read_data remains 16'hA5A5 throughout.
